// File: rtl/opb_status_bank_pkg.sv
// opb_status_bank_pkg: shared constants, word modes and OPB bit-order helper
package opb_status_bank_pkg;
  localparam logic [7:0] CTRL_OFFSET = 8'h80;
  localparam int SNAP_BIT = 0;
  localparam int CLR_BIT = 1;
  typedef enum logic [1:0] {MODE_LIVE, MODE_SNAP, MODE_STICKY} mode_e;
  typedef enum logic {S_IDLE, S_ACK} state_e;
  function automatic mode_e mode_of(input logic [31:0] snap_m, input logic [31:0] sticky_m, input int i);
    return sticky_m[5'(i)] ? MODE_STICKY : snap_m[5'(i)] ? MODE_SNAP : MODE_LIVE;
  endfunction
  // OPB numbers bits MSB-first, so OPB bit n carries word bit 31-n; works in both directions
  function automatic logic [0:31] opb_rev(input logic [31:0] w);
    return w;
  endfunction
endpackage

// File: rtl/opb_status_bank_if.sv
// opb_status_bank_if: OPB slave-side bus bundle
interface opb_status_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3] OPB_BE;
  logic [0:31] OPB_DBus;
  logic OPB_RNW;
  logic OPB_select;
  logic OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic Sl_xferAck;
  logic Sl_errAck;
  logic Sl_retry;
  logic Sl_toutSup;
  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
  modport slave (
    input OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_status_bank_status_word_cell.sv
// status_word_cell: one held status word in live, snapshot or sticky mode
module status_word_cell
  import opb_status_bank_pkg::*;
#(
  parameter mode_e MODE = MODE_LIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_i,
  input  logic        snap_i,
  input  logic        clr_i,
  output logic [31:0] q_o
);
  logic [31:0] q_q, q_d;
  // a clear keeps bits arriving in the same cycle so no event is lost
  always_comb
    q_d = MODE == MODE_STICKY ? (clr_i ? d_i : q_q | d_i) :
          MODE == MODE_SNAP   ? (snap_i ? d_i : q_q) : d_i;
  always_ff @(posedge clk)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/opb_status_bank.sv
// opb_status_bank: OPB slave exposing C_NUM_REGS live/snapshot/sticky status words plus a CTRL word
module opb_status_bank
  import opb_status_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h01008100,
  parameter logic [31:0] C_HIGHADDR    = 32'h010081FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter logic [31:0] C_SNAP_MASK   = 32'h0,
  parameter logic [31:0] C_STICKY_MASK = 32'h0
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  opb_status_bank_if.slave         bus,
  input  logic [C_NUM_REGS*32-1:0] user_data_in,
  input  logic                     user_snap
);
  logic [C_OPB_AWIDTH-1:0] addr, off;
  logic [C_OPB_DWIDTH-1:0] wdata, rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] held [C_NUM_REGS];
  logic [31:0] rd_or [C_NUM_REGS+1];
  logic [C_NUM_REGS-1:0] sel;
  state_e state_q, state_d;
  logic hit, accept, low, is_ctrl, ctrl_wr, snap, clr, unused;
  assign addr = bus.OPB_ABus;
  assign off = addr - C_BASEADDR;
  assign wdata = opb_rev(bus.OPB_DBus);
  assign hit = bus.OPB_select && addr >= C_BASEADDR && addr <= C_HIGHADDR;
  assign accept = hit && state_q == S_IDLE;
  assign low = off[C_OPB_AWIDTH-1:8] == '0;
  assign is_ctrl = low && off[7:2] == CTRL_OFFSET[7:2];
  assign ctrl_wr = accept && !bus.OPB_RNW && is_ctrl && bus.OPB_BE[3];
  assign snap = user_snap || (ctrl_wr && wdata[SNAP_BIT]);
  assign clr = ctrl_wr && wdata[CLR_BIT];
  assign cnt_d = cnt_q + 32'(snap);
  assign rd_or[0] = is_ctrl ? cnt_q : '0;
  assign rdata_d = accept ? (bus.OPB_RNW ? rd_or[C_NUM_REGS] : '0) : rdata_q;
  assign unused = ^{bus.OPB_seqAddr, off[1:0], wdata[31:2], bus.OPB_BE[0:2]};
  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_cell
    assign sel[i] = low && off[7:2] == 6'(i);
    assign rd_or[i+1] = rd_or[i] | (sel[i] ? held[i] : '0);
    status_word_cell #(.MODE(mode_of(C_SNAP_MASK, C_STICKY_MASK, i))) u_cell (
      .clk   (OPB_Clk),
      .rst   (OPB_Rst),
      .d_i   (user_data_in[32*i +: 32]),
      .snap_i(snap),
      .clr_i (clr || (accept && bus.OPB_RNW && sel[i])),
      .q_o   (held[i])
    );
  end
  always_ff @(posedge OPB_Clk)
    if (OPB_Rst) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb state_d = accept ? S_ACK : S_IDLE;
  always_comb begin
    bus.Sl_xferAck = state_q == S_ACK;
    bus.Sl_DBus = state_q == S_ACK ? opb_rev(rdata_q) : '0;
    bus.Sl_errAck = 1'b0;
    bus.Sl_retry = 1'b0;
    bus.Sl_toutSup = 1'b0;
  end
  always_ff @(posedge OPB_Clk)
    if (OPB_Rst) begin
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_opb_status_bank.sv
// tb_opb_status_bank: directed self-checking bench; word0 live, words 1/3 snapshot, word2 sticky
module tb_opb_status_bank;
  localparam logic [31:0] BASE = 32'h01008100;
  localparam logic [31:0] CTRL = BASE + 32'h80;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] udata = '0;
  logic usnap = 1'b0;
  int errs = 0;
  int checks = 0;
  opb_status_bank_if bus();
  opb_status_bank #(
    .C_NUM_REGS(4), .C_SNAP_MASK(32'hE), .C_STICKY_MASK(32'h4)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .bus(bus), .user_data_in(udata), .user_snap(usnap)
  );
  always #5 clk = ~clk;

  task automatic opb_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
    bus.OPB_ABus = a; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    @(negedge clk);
    ack = bus.Sl_xferAck; d = bus.Sl_DBus; bus.OPB_select = 1'b0;
    @(negedge clk);
  endtask

  task automatic opb_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic s, output logic ack);
    bus.OPB_ABus = a; bus.OPB_DBus = wd; bus.OPB_BE = be; bus.OPB_RNW = 1'b0;
    bus.OPB_select = 1'b1; usnap = s;
    @(negedge clk);
    ack = bus.Sl_xferAck; bus.OPB_select = 1'b0; usnap = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d; logic a;
    checks++; if (bus.Sl_xferAck !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b want 0", bus.Sl_xferAck); end
    checks++; if (bus.Sl_DBus !== 32'h0) begin errs++; $display("FAIL reset_dbus: got %h want 0", bus.Sl_DBus); end
    rst = 1'b0;
    @(negedge clk);
    opb_read(CTRL, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errs++; $display("FAIL reset_cnt: ack %b data %h want 1/00000000", a, d); end
    opb_read(BASE + 32'h8, d, a);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL reset_sticky: got %h want 0", d); end
  endtask

  task automatic test_live;
    udata[31:0] = 32'hDEADBEEF;
    @(negedge clk);
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    checks++; if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin errs++; $display("FAIL live_pre: ack %b data %h want 0/0", bus.Sl_xferAck, bus.Sl_DBus); end
    @(negedge clk);
    checks++; if (bus.Sl_xferAck !== 1'b1 || bus.Sl_DBus !== 32'hDEADBEEF) begin errs++; $display("FAIL live_ack: ack %b data %h want 1/deadbeef", bus.Sl_xferAck, bus.Sl_DBus); end
    bus.OPB_select = 1'b0;
    @(negedge clk);
    checks++; if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin errs++; $display("FAIL live_post: ack %b data %h want 0/0", bus.Sl_xferAck, bus.Sl_DBus); end
  endtask

  task automatic test_snapshot;
    logic [31:0] d; logic a;
    udata = {32'h33333333, 32'h0, 32'h11111111, 32'h0}; usnap = 1'b1;
    @(negedge clk);
    usnap = 1'b0; udata = {4{32'hAAAAAAAA}};
    @(negedge clk);
    opb_read(BASE + 32'h4, d, a);
    checks++; if (d !== 32'h11111111) begin errs++; $display("FAIL snap_w1: got %h want 11111111", d); end
    opb_read(BASE + 32'hC, d, a);
    checks++; if (d !== 32'h33333333) begin errs++; $display("FAIL snap_w3: got %h want 33333333", d); end
    opb_read(BASE, d, a);
    checks++; if (d !== 32'hAAAAAAAA) begin errs++; $display("FAIL snap_live: got %h want aaaaaaaa", d); end
    opb_read(CTRL, d, a);
    checks++; if (d !== 32'h1) begin errs++; $display("FAIL snap_cnt1: got %h want 1", d); end
    udata[63:32] = 32'h55555555;
    opb_write(CTRL, 32'h1, 4'b0001, 1'b0, a);
    checks++; if (a !== 1'b1) begin errs++; $display("FAIL sw_snap_ack: got %b want 1", a); end
    udata = '0;
    opb_read(BASE + 32'h4, d, a);
    checks++; if (d !== 32'h55555555) begin errs++; $display("FAIL sw_snap_w1: got %h want 55555555", d); end
    opb_read(CTRL, d, a);
    checks++; if (d !== 32'h2) begin errs++; $display("FAIL sw_snap_cnt: got %h want 2", d); end
  endtask

  task automatic test_sticky;
    logic [31:0] d; logic a;
    opb_read(BASE + 32'h8, d, a);
    checks++; if (d !== 32'hAAAAAAAA) begin errs++; $display("FAIL sticky_hold: got %h want aaaaaaaa", d); end
    udata[95:64] = 32'h8;
    @(negedge clk);
    udata[95:64] = 32'h100;
    @(negedge clk);
    udata[95:64] = 32'h0;
    @(negedge clk);
    opb_read(BASE + 32'h8, d, a);
    checks++; if (d !== 32'h108) begin errs++; $display("FAIL sticky_or: got %h want 00000108", d); end
    opb_read(BASE + 32'h8, d, a);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL sticky_cleared: got %h want 0", d); end
    udata[95:64] = 32'h1;
    opb_read(BASE + 32'h8, d, a);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL sticky_prior: got %h want 0", d); end
    udata[95:64] = 32'h0;
    opb_read(BASE + 32'h8, d, a);
    checks++; if (d !== 32'h1) begin errs++; $display("FAIL sticky_survive: got %h want 1", d); end
  endtask

  task automatic test_ctrl;
    logic [31:0] d; logic a;
    udata[95:64] = 32'h4;
    @(negedge clk);
    udata[95:64] = 32'h0;
    opb_write(CTRL, 32'h3, 4'b0001, 1'b1, a);
    opb_read(CTRL, d, a);
    checks++; if (d !== 32'h3) begin errs++; $display("FAIL ctrl_one_event: got %h want 3", d); end
    opb_read(BASE + 32'h8, d, a);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL ctrl_clear: got %h want 0", d); end
    opb_read(BASE + 32'h4, d, a);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL ctrl_snap_w1: got %h want 0", d); end
    udata[95:64] = 32'h4;
    @(negedge clk);
    udata[95:64] = 32'h0;
    opb_write(CTRL, 32'h3, 4'b1000, 1'b0, a);
    checks++; if (a !== 1'b1) begin errs++; $display("FAIL ctrl_be_ack: got %b want 1", a); end
    opb_read(CTRL, d, a);
    checks++; if (d !== 32'h3) begin errs++; $display("FAIL ctrl_be_cnt: got %h want 3", d); end
    opb_read(BASE + 32'h8, d, a);
    checks++; if (d !== 32'h4) begin errs++; $display("FAIL ctrl_be_sticky: got %h want 4", d); end
    opb_write(BASE + 32'h4, 32'hFFFFFFFF, 4'b1111, 1'b0, a);
    opb_read(BASE + 32'h4, d, a);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL word_write_ignored: got %h want 0", d); end
  endtask

  task automatic test_wrap;
    logic [31:0] d; logic a;
    force dut.cnt_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.cnt_q;
    opb_read(CTRL, d, a);
    checks++; if (d !== 32'hFFFFFFFF) begin errs++; $display("FAIL wrap_preload: got %h want ffffffff", d); end
    usnap = 1'b1;
    @(negedge clk);
    usnap = 1'b0;
    opb_read(CTRL, d, a);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL wrap_zero: got %h want 0", d); end
  endtask

  task automatic test_back_to_back;
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.Sl_xferAck !== 1'(k % 2)) begin errs++; $display("FAIL b2b_ack%0d: got %b want %0d", k, bus.Sl_xferAck, k % 2); end
      @(negedge clk);
    end
    bus.OPB_select = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_decode;
    logic [31:0] d; logic a;
    opb_read(32'h01008200, d, a);
    checks++; if (a !== 1'b0) begin errs++; $display("FAIL miss_ack: got %b want 0", a); end
    udata = {4{32'hFFFFFFFF}};
    @(negedge clk);
    opb_read(BASE + 32'h40, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errs++; $display("FAIL hole_0x40: ack %b data %h want 1/0", a, d); end
    opb_read(BASE + 32'h84, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errs++; $display("FAIL hole_0x84: ack %b data %h want 1/0", a, d); end
    udata = '0;
  endtask

  task automatic test_reset_mid;
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1; rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.Sl_xferAck !== 1'b0) begin errs++; $display("FAIL rst_accept_ack: got %b want 0", bus.Sl_xferAck); end
    rst = 1'b0; bus.OPB_select = 1'b0;
    @(negedge clk);
    checks++; if (bus.Sl_xferAck !== 1'b0) begin errs++; $display("FAIL rst_no_retry: got %b want 0", bus.Sl_xferAck); end
  endtask

  initial begin
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_live;
    test_snapshot;
    test_sticky;
    test_ctrl;
    test_wrap;
    test_back_to_back;
    test_decode;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
